// File: rtl/traffic_pkg.sv
// Shared types and constants for the four-way junction phase controller.
// Light codes, phase encoding, road indices and the occupancy count width.
package traffic_pkg;

    localparam int CNT_W = 8;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] GREEN  = 2'd1;
    localparam logic [1:0] YELLOW = 2'd2;

    localparam logic [1:0] ROAD_A = 2'd0;
    localparam logic [1:0] ROAD_B = 2'd1;
    localparam logic [1:0] ROAD_C = 2'd2;
    localparam logic [1:0] ROAD_D = 2'd3;

    typedef enum logic [1:0] {
        PH_ALL_RED   = 2'd0,
        PH_GREEN_MIN = 2'd1,
        PH_GREEN_EXT = 2'd2,
        PH_YELLOW    = 2'd3
    } phase_t;

    // Packed light word, road r in bits [2r+1:2r]; only road gets code.
    function automatic logic [7:0] light_vec(
        input logic [1:0] road,
        input logic [1:0] code
    );
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            if (road == 2'(i)) begin
                v[2*i +: 2] = code;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/traffic_phase_controller_arbiter.sv
// road_arbiter: combinational next-road selection for the junction.
// Ports: four counts, four skip counters, active road, max_skip -> grant.
module road_arbiter
    import traffic_pkg::*;
(
    input  logic [CNT_W-1:0] count_a,
    input  logic [CNT_W-1:0] count_b,
    input  logic [CNT_W-1:0] count_c,
    input  logic [CNT_W-1:0] count_d,
    input  logic [3:0]       skip_a,
    input  logic [3:0]       skip_b,
    input  logic [3:0]       skip_c,
    input  logic [3:0]       skip_d,
    input  logic [1:0]       active,
    input  logic [3:0]       max_skip,
    output logic [1:0]       grant
);

    logic [CNT_W-1:0] cnt [4];
    logic [3:0]       skp [4];

    assign cnt[0] = count_a;
    assign cnt[1] = count_b;
    assign cnt[2] = count_c;
    assign cnt[3] = count_d;
    assign skp[0] = skip_a;
    assign skp[1] = skip_b;
    assign skp[2] = skip_c;
    assign skp[3] = skip_d;

    logic [1:0]       idx;
    logic             found;
    logic [1:0]       forced;
    logic [1:0]       best;
    logic [CNT_W-1:0] best_cnt;

    // Scan order is active+1 .. active+4; the last slot is active itself.
    // Seeding best with active+1 covers the all-zero case, and the
    // strict compare keeps ties on the earliest road in scan order.
    always_comb begin
        idx      = '0;
        found    = 1'b0;
        forced   = active + 2'd1;
        best     = active + 2'd1;
        best_cnt = cnt[active + 2'd1];
        for (int i = 1; i <= 4; i++) begin
            idx = active + 2'(i);
            if (!found && (skp[idx] >= max_skip)) begin
                found  = 1'b1;
                forced = idx;
            end
            if (cnt[idx] > best_cnt) begin
                best     = idx;
                best_cnt = cnt[idx];
            end
        end
        grant = found ? forced : best;
    end

endmodule

// File: rtl/traffic_phase_controller.sv
// Four-way junction phase controller: one green at a time, occupancy-scaled.
// Ports: clk, reset(async low), Tick, CountA..D in; LightA..D, ActiveRoad, Phase, PhaseTimer out.
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN   = 5,
    parameter int MAX_GREEN   = 30,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 1,
    parameter int SCALE_SHIFT = 1,
    parameter int MAX_SKIP    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Tick,
    input  logic [CNT_W-1:0] CountA,
    input  logic [CNT_W-1:0] CountB,
    input  logic [CNT_W-1:0] CountC,
    input  logic [CNT_W-1:0] CountD,
    output logic [1:0]       LightA,
    output logic [1:0]       LightB,
    output logic [1:0]       LightC,
    output logic [1:0]       LightD,
    output logic [1:0]       ActiveRoad,
    output logic [1:0]       Phase,
    output logic [7:0]       PhaseTimer
);

    localparam logic [7:0] MIN_T   = 8'(MIN_GREEN);
    localparam logic [7:0] YEL_T   = 8'(YELLOW_TIME);
    localparam logic [7:0] ARED_T  = 8'(ALLRED_TIME);
    localparam logic [7:0] EXT_MAX = 8'(MAX_GREEN - MIN_GREEN);
    localparam logic [3:0] SKIP_T  = 4'(MAX_SKIP);

    phase_t     phase_q;
    logic [7:0] timer_q;
    logic [1:0] active_q;
    logic [7:0] lights_q;
    logic [3:0] skip_q [4];

    logic [CNT_W-1:0] cnt [4];
    logic [CNT_W-1:0] act_cnt;
    logic [CNT_W-1:0] ext_raw;
    logic [7:0]       ext;
    logic             timer_zero;
    logic [1:0]       grant;

    assign cnt[0] = CountA;
    assign cnt[1] = CountB;
    assign cnt[2] = CountC;
    assign cnt[3] = CountD;

    assign act_cnt    = cnt[active_q];
    assign ext_raw    = act_cnt >> SCALE_SHIFT;
    assign ext        = (ext_raw > EXT_MAX) ? EXT_MAX : ext_raw;
    assign timer_zero = (timer_q == 8'd0);

    road_arbiter u_arb (
        .count_a  (CountA),
        .count_b  (CountB),
        .count_c  (CountC),
        .count_d  (CountD),
        .skip_a   (skip_q[0]),
        .skip_b   (skip_q[1]),
        .skip_c   (skip_q[2]),
        .skip_d   (skip_q[3]),
        .active   (active_q),
        .max_skip (SKIP_T),
        .grant    (grant)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q  <= PH_ALL_RED;
            timer_q  <= ARED_T;
            active_q <= ROAD_D;
            lights_q <= '0;
            for (int i = 0; i < 4; i++) begin
                skip_q[i] <= 4'd0;
            end
        end else begin
            // Default countdown; phase exits below override the load.
            if (!timer_zero && Tick) begin
                timer_q <= timer_q - 8'd1;
            end
            unique case (phase_q)
                PH_ALL_RED: begin
                    if (timer_zero) begin
                        phase_q  <= PH_GREEN_MIN;
                        timer_q  <= MIN_T;
                        active_q <= grant;
                        lights_q <= light_vec(grant, GREEN);
                        for (int i = 0; i < 4; i++) begin
                            if (grant == 2'(i)) begin
                                skip_q[i] <= 4'd0;
                            end else if (skip_q[i] != 4'd15) begin
                                skip_q[i] <= skip_q[i] + 4'd1;
                            end
                        end
                    end
                end
                PH_GREEN_MIN: begin
                    if (timer_zero) begin
                        if (ext == 8'd0) begin
                            phase_q  <= PH_YELLOW;
                            timer_q  <= YEL_T;
                            lights_q <= light_vec(active_q, YELLOW);
                        end else begin
                            phase_q <= PH_GREEN_EXT;
                            timer_q <= ext;
                        end
                    end
                end
                PH_GREEN_EXT: begin
                    // Empty approach ends the extension without waiting.
                    if (timer_zero || (act_cnt == '0)) begin
                        phase_q  <= PH_YELLOW;
                        timer_q  <= YEL_T;
                        lights_q <= light_vec(active_q, YELLOW);
                    end
                end
                PH_YELLOW: begin
                    if (timer_zero) begin
                        phase_q  <= PH_ALL_RED;
                        timer_q  <= ARED_T;
                        lights_q <= '0;
                    end
                end
                default: begin
                    phase_q  <= PH_ALL_RED;
                    timer_q  <= ARED_T;
                    lights_q <= '0;
                end
            endcase
        end
    end

    assign LightA     = lights_q[1:0];
    assign LightB     = lights_q[3:2];
    assign LightC     = lights_q[5:4];
    assign LightD     = lights_q[7:6];
    assign ActiveRoad = active_q;
    assign Phase      = phase_q;
    assign PhaseTimer = timer_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed scoreboard bench for traffic_phase_controller.
// Expected phase/length/road tuples are queued, then matched against observed phases.
module tb_traffic_phase_controller;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       Tick;
    logic [7:0] CountA, CountB, CountC, CountD;
    logic [1:0] LightA, LightB, LightC, LightD;
    logic [1:0] ActiveRoad, Phase;
    logic [7:0] PhaseTimer;

    always #5 clk = ~clk;

    traffic_phase_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Tick       (Tick),
        .CountA     (CountA),
        .CountB     (CountB),
        .CountC     (CountC),
        .CountD     (CountD),
        .LightA     (LightA),
        .LightB     (LightB),
        .LightC     (LightC),
        .LightD     (LightD),
        .ActiveRoad (ActiveRoad),
        .Phase      (Phase),
        .PhaseTimer (PhaseTimer)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] ph;
        int         len;
        logic [1:0] road;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] light_of(input int r);
        case (r)
            0:       return LightA;
            1:       return LightB;
            2:       return LightC;
            default: return LightD;
        endcase
    endfunction

    // Samples from the first cycle of the current phase until it changes.
    task automatic run_phase(output logic [1:0] ph, output int len,
                             output logic [1:0] road, output logic ok);
        logic [1:0] code;
        ph   = Phase;
        road = ActiveRoad;
        len  = 0;
        ok   = 1'b1;
        while (Phase === ph && len < 300) begin
            for (int i = 0; i < 4; i++) begin
                if (road != 2'(i))     code = RED;
                else if (ph == 2'd3)   code = YELLOW;
                else if (ph == 2'd0)   code = RED;
                else                   code = GREEN;
                if (light_of(i) !== code) ok = 1'b0;
            end
            if (ActiveRoad !== road) ok = 1'b0;
            len++;
            step();
        end
    endtask

    task automatic push(input logic [1:0] ph, input int len,
                        input logic [1:0] road);
        exp_t e;
        e.ph   = ph;
        e.len  = len;
        e.road = road;
        sb.push_back(e);
    endtask

    // With Tick every cycle a phase loaded with N occupies N+1 cycles.
    task automatic push_grant(input logic [1:0] prev, input logic [1:0] road,
                              input int ext);
        push(2'd0, 2, prev);
        push(2'd1, 6, road);
        if (ext > 0) push(2'd2, ext + 1, road);
        push(2'd3, 4, road);
    endtask

    task automatic drain(input string tag);
        exp_t       e;
        logic [1:0] ph;
        int         len;
        logic [1:0] road;
        logic       ok;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            run_phase(ph, len, road, ok);
            check({tag, "_phase"}, 32'(ph), 32'(e.ph));
            check({tag, "_len"}, 32'(len), 32'(e.len));
            check({tag, "_road"}, 32'(road), 32'(e.road));
            check({tag, "_lights"}, 32'(ok), 32'd1);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rst_phase"}, 32'(Phase), 32'd0);
        check({tag, "_rst_lights"}, 32'({LightD, LightC, LightB, LightA}), 32'd0);
        check({tag, "_rst_road"}, 32'(ActiveRoad), 32'd3);
        check({tag, "_rst_timer"}, 32'(PhaseTimer), 32'd1);
    endtask

    task automatic do_reset(input string tag, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] c,
                            input logic [7:0] d);
        reset  = 1'b0;
        Tick   = 1'b1;
        CountA = a;
        CountB = b;
        CountC = c;
        CountD = d;
        step();
        step();
        check_reset_state(tag);
        reset = 1'b1;
    endtask

    initial begin
        logic frozen;
        reset  = 1'b0;
        Tick   = 1'b1;
        CountA = '0;
        CountB = '0;
        CountC = '0;
        CountD = '0;

        // Basic: B=10, C=4 -> B green 5+5, yellow 3, all-red 1.
        do_reset("basic", 8'd0, 8'd10, 8'd4, 8'd0);
        push_grant(2'd3, 2'd1, 5);
        push(2'd0, 2, 2'd1);
        drain("basic");

        // Heavy B with starvation guard forcing C, D, A.
        do_reset("skip", 8'd1, 8'd200, 8'd1, 8'd1);
        push_grant(2'd3, 2'd1, 25);
        push_grant(2'd1, 2'd1, 25);
        push_grant(2'd1, 2'd1, 25);
        push_grant(2'd1, 2'd2, 0);
        push_grant(2'd2, 2'd3, 0);
        push_grant(2'd3, 2'd0, 0);
        push_grant(2'd0, 2'd1, 25);
        drain("skip");

        // Tie between A and B.
        do_reset("tie", 8'd7, 8'd7, 8'd0, 8'd0);
        push_grant(2'd3, 2'd0, 3);
        push_grant(2'd0, 2'd1, 3);
        drain("tie");

        // Gap-out on C during extension.
        do_reset("gap", 8'd0, 8'd0, 8'd40, 8'd0);
        push(2'd0, 2, 2'd3);
        push(2'd1, 6, 2'd2);
        drain("gap");
        check("gap_ext_phase", 32'(Phase), 32'd2);
        check("gap_ext_timer", 32'(PhaseTimer), 32'd20);
        step();
        check("gap_ext_timer2", 32'(PhaseTimer), 32'd19);
        CountC = 8'd0;
        step();
        check("gap_yel_phase", 32'(Phase), 32'd3);
        check("gap_yel_light", 32'(LightC), 32'(YELLOW));
        check("gap_yel_timer", 32'(PhaseTimer), 32'd3);

        // All counts zero: strict rotation with minimum green only.
        do_reset("zero", 8'd0, 8'd0, 8'd0, 8'd0);
        push_grant(2'd3, 2'd0, 0);
        push_grant(2'd0, 2'd1, 0);
        push_grant(2'd1, 2'd2, 0);
        push_grant(2'd2, 2'd3, 0);
        drain("zero");

        // Async reset during GREEN_EXT, then frozen timers with Tick low.
        do_reset("rx", 8'd0, 8'd10, 8'd0, 8'd0);
        push(2'd0, 2, 2'd3);
        push(2'd1, 6, 2'd1);
        drain("rx");
        step();
        step();
        check("rx_in_ext", 32'(Phase), 32'd2);
        #2 reset = 1'b0;
        #1 check_reset_state("rx_async");
        Tick  = 1'b0;
        reset = 1'b1;
        frozen = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (Phase !== 2'd0 || PhaseTimer !== 8'd1) frozen = 1'b0;
        end
        check("freeze", 32'(frozen), 32'd1);

        // Resume, then async reset during YELLOW.
        Tick = 1'b1;
        push(2'd0, 2, 2'd3);
        push(2'd1, 6, 2'd1);
        push(2'd2, 6, 2'd1);
        drain("ry");
        check("ry_in_yel", 32'(Phase), 32'd3);
        step();
        #2 reset = 1'b0;
        #1 check_reset_state("ry_async");
        reset = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
